carry_look_ahead_adder: RTL and testbench

Parameterised two-operand unsigned/two's-complement adder built from a two-level carry-lookahead network, with a registered sum and carry-out. It serves as the ADD datapath of the Phase 1 bus-architecture ALU: operands come from the ALU input registers and the result feeds the ALU result register/bus. It uses no carry ripple longer than one 4-bit group.

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/cla_group_4.sv | 28 ++
 rtl/cla_lookahead_4.sv | 21 ++
 rtl/carry_look_ahead_adder.sv | 89 ++++++++
 tb/tb_carry_look_ahead_adder.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU constants and carry-lookahead helper equations.
//   DATA_WIDTH  default datapath width
//   CLA_GROUP   bits per lookahead group
//   CLR_ACTIVE  level of clr that holds the ALU in reset
package alu_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned CLA_GROUP  = 4;
    localparam logic        CLR_ACTIVE = 1'b0;

    // Number of 4-ary lookahead levels needed above n groups (at least one).
    function automatic int unsigned cla_levels(input int unsigned n);
        int unsigned span;
        int unsigned lvl;
        span = 1;
        lvl  = 0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (span < n) begin
                span = span * 4;
                lvl  = lvl + 1;
            end
        end
        return (lvl == 0) ? 1 : lvl;
    endfunction

    // Fully expanded carries into each of four positions; c[0] is the carry-in.
    function automatic logic [3:0] cla_carries(input logic [3:0] g, input logic [3:0] p,
                                               input logic cin);
        logic [3:0] c;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        return c;
    endfunction

    function automatic logic cla_generate(input logic [3:0] g, input logic [3:0] p);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    function automatic logic cla_propagate(input logic [3:0] p);
        return &p;
    endfunction

endpackage

// File: rtl/cla_group_4.sv
// 4-bit carry-lookahead group: sum bits plus group generate/propagate.
//   a, b  addend nibbles
//   cin   carry into bit 0 of the group
//   s     sum nibble
//   G, P  group generate / propagate for the next lookahead level
module cla_group_4
    import alu_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       G,
    output logic       P
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;
    assign c = cla_carries(g, p, cin);
    assign s = p ^ c;
    assign G = cla_generate(g, p);
    assign P = cla_propagate(p);

endmodule

// File: rtl/cla_lookahead_4.sv
// One node of the lookahead tree: combines four child generate/propagate pairs.
//   grp_g, grp_p  child generate / propagate (bit 0 is least significant child)
//   cin           carry into the least significant child
//   c             carry into each child
//   blk_g, blk_p  generate / propagate of the whole block
module cla_lookahead_4
    import alu_pkg::*;
(
    input  logic [3:0] grp_g,
    input  logic [3:0] grp_p,
    input  logic       cin,
    output logic [3:0] c,
    output logic       blk_g,
    output logic       blk_p
);

    assign c     = cla_carries(grp_g, grp_p, cin);
    assign blk_g = cla_generate(grp_g, grp_p);
    assign blk_p = cla_propagate(grp_p);

endmodule

// File: rtl/carry_look_ahead_adder.sv
// Registered BITS-wide carry-lookahead adder (carry-in 0), one result per cycle.
//   clk               rising-edge clock
//   clr               asynchronous active-low reset, clears the output register
//   summand1_32_bits  first addend
//   summand2_32_bits  second addend
//   outputSum         registered (a + b) mod 2^BITS
//   carryOut          registered carry out of bit BITS-1
module carry_look_ahead_adder
    import alu_pkg::*;
#(
    parameter int unsigned BITS = DATA_WIDTH
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [BITS-1:0] summand1_32_bits,
    input  logic [BITS-1:0] summand2_32_bits,
    output logic [BITS-1:0] outputSum,
    output logic            carryOut
);

    localparam int unsigned NumGroups = BITS / CLA_GROUP;
    localparam int unsigned Levels    = cla_levels(NumGroups);
    localparam int unsigned NumLeaves = 4 ** Levels;
    // Tree stored as a 4-ary heap: node n has children 4n+1..4n+4, leaves last.
    localparam int unsigned NumNodes  = (4 * NumLeaves - 1) / 3;
    localparam int unsigned LeafBase  = (NumLeaves - 1) / 3;

    if ((BITS % CLA_GROUP) != 0 || BITS < CLA_GROUP) begin : g_bad_width
        $error("BITS must be a multiple of 4 and at least 4");
    end

    logic [NumNodes-1:0] node_g;
    logic [NumNodes-1:0] node_p;
    logic [NumNodes-1:0] node_c;
    logic [BITS-1:0]     sum_d;
    logic                cout_d;
    logic [BITS-1:0]     sum_q;
    logic                cout_q;

    assign node_c[0] = 1'b0;

    for (genvar n = 0; n < LeafBase; n++) begin : g_tree
        cla_lookahead_4 u_lookahead (
            .grp_g (node_g[4*n+1 +: 4]),
            .grp_p (node_p[4*n+1 +: 4]),
            .cin   (node_c[n]),
            .c     (node_c[4*n+1 +: 4]),
            .blk_g (node_g[n]),
            .blk_p (node_p[n])
        );
    end

    for (genvar k = 0; k < NumLeaves; k++) begin : g_leaf
        if (k < NumGroups) begin : g_group
            cla_group_4 u_group (
                .a   (summand1_32_bits[4*k +: 4]),
                .b   (summand2_32_bits[4*k +: 4]),
                .cin (node_c[LeafBase+k]),
                .s   (sum_d[4*k +: 4]),
                .G   (node_g[LeafBase+k]),
                .P   (node_p[LeafBase+k])
            );
        end else begin : g_pad
            // Padding groups pass carries through so the root G is c[BITS].
            assign node_g[LeafBase+k] = 1'b0;
            assign node_p[LeafBase+k] = 1'b1;
        end
    end

    assign cout_d = node_g[0] | (node_p[0] & node_c[0]);

    // Carries into padding leaves have no consumer.
    logic unused_node_c;
    assign unused_node_c = ^node_c;

    always_ff @(posedge clk or negedge clr) begin
        if (clr == CLR_ACTIVE) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign outputSum = sum_q;
    assign carryOut  = cout_q;

endmodule

// File: tb/tb_carry_look_ahead_adder.sv
module tb_carry_look_ahead_adder;

    logic        clk;
    logic        clr;
    logic [31:0] a32, b32, sum32;
    logic        cout32;
    logic [7:0]  a8, b8, sum8;
    logic        cout8;

    int n_cmp;
    int n_bad;

    carry_look_ahead_adder #(.BITS(32)) dut32 (
        .clk              (clk),
        .clr              (clr),
        .summand1_32_bits (a32),
        .summand2_32_bits (b32),
        .outputSum        (sum32),
        .carryOut         (cout32)
    );

    carry_look_ahead_adder #(.BITS(8)) dut8 (
        .clk              (clk),
        .clr              (clr),
        .summand1_32_bits (a8),
        .summand2_32_bits (b8),
        .outputSum        (sum8),
        .carryOut         (cout8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
        logic        cout;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Next rising edge, then sample on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [32:0] ref32;
    logic [8:0]  ref8;

    initial begin
        n_cmp = 0;
        n_bad = 0;

        vecs[0] = '{"4+3",        32'd4,          32'd3,          32'd7,          1'b0};
        vecs[1] = '{"10+11",      32'd10,         32'd11,         32'd21,         1'b0};
        vecs[2] = '{"3+5",        32'd3,          32'd5,          32'd8,          1'b0};
        vecs[3] = '{"7+7",        32'd7,          32'd7,          32'd14,         1'b0};
        vecs[4] = '{"grp_carry",  32'h0000_000F,  32'h0000_0001,  32'h0000_0010,  1'b0};
        vecs[5] = '{"blk_carry",  32'h0000_FFFF,  32'h0000_0001,  32'h0001_0000,  1'b0};
        vecs[6] = '{"top_carry",  32'h0FFF_FFFF,  32'h0000_0001,  32'h1000_0000,  1'b0};
        vecs[7] = '{"wrap_ones",  32'hFFFF_FFFF,  32'h0000_0001,  32'h0000_0000,  1'b1};
        vecs[8] = '{"wrap_msb",   32'h8000_0000,  32'h8000_0000,  32'h0000_0000,  1'b1};
        vecs[9] = '{"wrap_max",   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  1'b1};

        // Reset: immediate clear, then held across edges.
        clr = 1'b1;
        a32 = 32'd4;
        b32 = 32'd3;
        a8  = 8'd4;
        b8  = 8'd3;
        #2;
        clr = 1'b0;
        #1;
        check("rst_now_sum32", 64'(sum32), 64'd0);
        check("rst_now_cout32", 64'(cout32), 64'd0);
        check("rst_now_sum8", 64'(sum8), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_hold_sum32", 64'(sum32), 64'd0);
            check("rst_hold_cout32", 64'(cout32), 64'd0);
        end
        clr = 1'b1;
        step();
        check("rst_rel_sum32", 64'(sum32), 64'd7);
        check("rst_rel_sum8", 64'(sum8), 64'd7);

        // Directed table, one operand pair per cycle.
        for (int i = 0; i < 10; i++) begin
            a32 = vecs[i].a;
            b32 = vecs[i].b;
            step();
            check({vecs[i].name, "_sum"}, 64'(sum32), 64'(vecs[i].sum));
            check({vecs[i].name, "_cout"}, 64'(cout32), 64'(vecs[i].cout));
        end

        // Operands changing between edges must not disturb the held result.
        a32 = 32'd1;
        b32 = 32'd1;
        #2;
        check("hold_sum32", 64'(sum32), 64'hFFFF_FFFE);
        check("hold_cout32", 64'(cout32), 64'd1);

        // Mid-stream reset discards the in-flight 10+11.
        @(negedge clk);
        a32 = 32'd10;
        b32 = 32'd11;
        a8  = 8'hFF;
        b8  = 8'h01;
        clr = 1'b0;
        #1;
        check("mid_rst_now", 64'(sum32), 64'd0);
        step();
        check("mid_rst_edge_sum", 64'(sum32), 64'd0);
        check("mid_rst_edge_cout", 64'(cout32), 64'd0);
        check("mid_rst_edge_sum8", 64'(sum8), 64'd0);
        a32 = 32'd20;
        b32 = 32'd22;
        clr = 1'b1;
        step();
        check("mid_rst_rel_sum", 64'(sum32), 64'd42);
        check("wrap8_sum", 64'(sum8), 64'd0);
        check("wrap8_cout", 64'(cout8), 64'd1);
        a8 = 8'h0F;
        b8 = 8'h01;
        step();
        check("grp8_sum", 64'(sum8), 64'h10);
        check("grp8_cout", 64'(cout8), 64'd0);

        // Randomised sweep against plain arithmetic, one cycle behind.
        a32 = $urandom;
        b32 = $urandom;
        a8  = 8'($urandom);
        b8  = 8'($urandom);
        ref32 = {1'b0, a32} + {1'b0, b32};
        ref8  = {1'b0, a8} + {1'b0, b8};
        for (int i = 0; i < 10000; i++) begin
            step();
            check("rand_sum32", 64'(sum32), 64'(ref32[31:0]));
            check("rand_cout32", 64'(cout32), 64'(ref32[32]));
            check("rand_sum8", 64'(sum8), 64'(ref8[7:0]));
            check("rand_cout8", 64'(cout8), 64'(ref8[8]));
            // Bias some pairs toward long carry chains.
            if ((i % 8) == 0) begin
                a32 = $urandom;
                b32 = ~a32 ^ 32'(1 << $urandom_range(31, 0));
                a8  = 8'($urandom);
                b8  = ~a8;
            end else begin
                a32 = $urandom;
                b32 = $urandom;
                a8  = 8'($urandom);
                b8  = 8'($urandom);
            end
            ref32 = {1'b0, a32} + {1'b0, b32};
            ref8  = {1'b0, a8} + {1'b0, b8};
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
